pipe_hazard_ctrl: RTL

//  Generates the stall/flush controls consumed by the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers.

---
 rtl/pipe_hazard_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush generator: load-use, taken branch and data-memory wait with timeout watchdog.
// Optional perf counters are compiled in when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int REG_W       = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic             ID_use_rs,
  input  logic             ID_use_rt,
  input  logic             EX_memread,
  input  logic [REG_W-1:0] EX_wreg,
  input  logic             EX_br_taken,
  input  logic             MEM_memread,
  input  logic             MEM_memwrite,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             IF_ID_stall,
  output logic             IF_ID_flush,
  output logic             ID_EX_stall,
  output logic             ID_EX_flush,
  output logic             EX_MEM_stall,
  output logic             EX_MEM_flush,
  output logic             MEM_WB_flush,
  output logic             dmem_req,
  output logic             dmem_err,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
);

  typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_ERR} state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

  state_e     state_q;
  logic [7:0] wait_cnt_q;

  logic mem_acc;
  logic mem_wait;
  logic in_err;
  logic load_use;

  assign mem_acc  = MEM_memread | MEM_memwrite;
  assign in_err   = (state_q == S_ERR);
  assign mem_wait = ((state_q == S_RUN) & mem_acc & ~dmem_ready) |
                    ((state_q == S_MEM_WAIT) & ~dmem_ready);
  assign load_use = EX_memread & (EX_wreg != '0) &
                    ((ID_use_rs & (ID_rs == EX_wreg)) | (ID_use_rt & (ID_rt == EX_wreg)));

  // NOTE: every output gets a default before the priority chain so no latch is inferred.
  always_comb begin
    pc_stall     = 1'b0;
    IF_ID_stall  = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_stall  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_stall = 1'b0;
    MEM_WB_flush = 1'b0;
    if (rst_n) begin
      if (in_err || mem_wait) begin
        // Whole front of the pipe is frozen; a bubble drains into WB.
        pc_stall     = 1'b1;
        IF_ID_stall  = 1'b1;
        ID_EX_stall  = 1'b1;
        EX_MEM_stall = 1'b1;
        MEM_WB_flush = 1'b1;
      end else if (EX_br_taken) begin
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
      end else if (load_use) begin
        pc_stall    = 1'b1;
        IF_ID_stall = 1'b1;
        ID_EX_flush = 1'b1;
      end
    end
  end

  assign EX_MEM_flush = 1'b0;
  assign dmem_req     = rst_n & mem_acc & ~in_err;
  assign dmem_err     = rst_n & in_err;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      wait_cnt_q <= '0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (mem_acc && !dmem_ready) begin
            state_q    <= S_MEM_WAIT;
            wait_cnt_q <= 8'd1;
          end
        end
        S_MEM_WAIT: begin
          if (dmem_ready) begin
            state_q    <= S_RUN;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == TIMEOUT_C) begin
            state_q <= S_ERR;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        S_ERR:   state_q <= S_ERR;
        default: state_q <= S_RUN;
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (ID_EX_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule
